// File: rtl/io_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// CSR bit positions and the transmit state encoding.
package io_uart_pkg;

  localparam int DATA_OFF = 0;
  localparam int CSR_OFF  = 1;
  localparam int DIV_OFF  = 2;

  localparam int CSR_EN        = 0;
  localparam int CSR_IRQ_EN    = 1;
  localparam int CSR_PAR_EN    = 2;
  localparam int CSR_OVF       = 3;
  localparam int CSR_FULL      = 8;
  localparam int CSR_EMPTY     = 9;
  localparam int CSR_BUSY      = 10;
  localparam int CSR_COUNT_LSB = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

endpackage

// File: rtl/io_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count; a push into a
// full FIFO is accepted only when a pop happens on the same edge.
module io_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: storage has no reset; the pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/io_uart_tx.sv
// UART transmitter peripheral: DATA/CSR/DIV registers at IO_BASE, transmit FIFO,
// runtime baud divisor, sticky overflow and level irq. Define IO_UART_TX_PARITY_EN
// to add the CSR par_en bit and an even-parity bit after the data bits.
module io_uart_tx
  import io_uart_pkg::*;
#(
  parameter int                ADDR_W      = 8,
  parameter int                DATA_W      = 32,
  parameter int                FIFO_DEPTH  = 8,
  parameter int                DIV_W       = 16,
  parameter logic [DIV_W-1:0]  DEFAULT_DIV = DIV_W'(434),
  parameter logic [ADDR_W-1:0] IO_BASE     = ADDR_W'(8'h10)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  input  logic              io_we,
  output logic [DATA_W-1:0] io_rdata,
  output logic              uart_tx,
  output logic              irq
);

  localparam int CW = ((FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1) + 1;
  localparam logic [ADDR_W-1:0] A_DATA = IO_BASE + ADDR_W'(DATA_OFF);
  localparam logic [ADDR_W-1:0] A_CSR  = IO_BASE + ADDR_W'(CSR_OFF);
  localparam logic [ADDR_W-1:0] A_DIV  = IO_BASE + ADDR_W'(DIV_OFF);

  logic             wr_data, wr_csr, wr_div;
  logic             en_q, irq_en_q, par_en_q, ovf_q, irq_q;
  logic [DIV_W-1:0] div_q, div_eff;
  logic             fifo_full, fifo_empty, pop;
  logic [7:0]       fifo_rdata;
  logic [CW-1:0]    fifo_count;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [31:0]      csr_word;
  logic             unused_ok;

  tx_state_t        state_q, state_d;
  logic [DIV_W-1:0] timer_q, timer_d, period_q, period_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d, busy, start_cond, bit_done;

  assign wr_data   = io_we && (io_addr == A_DATA);
  assign wr_csr    = io_we && (io_addr == A_CSR);
  assign wr_div    = io_we && (io_addr == A_DIV);
  assign unused_ok = ^io_wdata;

  io_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (wr_data),
    .wdata (io_wdata[7:0]),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q     <= 1'b0;
      irq_en_q <= 1'b0;
      ovf_q    <= 1'b0;
      div_q    <= DEFAULT_DIV;
    end else begin
      if (wr_csr) begin
        en_q     <= io_wdata[CSR_EN];
        irq_en_q <= io_wdata[CSR_IRQ_EN];
      end
      if (wr_div) div_q <= io_wdata[DIV_W-1:0];
      // An overflowing push wins over a same-cycle write-one-to-clear.
      if (wr_data && fifo_full && !pop)      ovf_q <= 1'b1;
      else if (wr_csr && io_wdata[CSR_OVF])  ovf_q <= 1'b0;
    end
  end

`ifdef IO_UART_TX_PARITY_EN
  logic par_q, par_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
    end else begin
      if (wr_csr) par_en_q <= io_wdata[CSR_PAR_EN];
      par_q <= par_d;
    end
  end
`else
  assign par_en_q = 1'b0;
`endif

  assign div_eff    = (div_q == '0) ? DIV_W'(1) : div_q;
  assign start_cond = en_q && !fifo_empty;
  assign bit_done   = (timer_q == '0);
  assign busy       = (state_q != ST_IDLE);

  // NOTE: always_comb uses blocking (=) and assigns every output a default first,
  // so no latch is inferred; the registers it feeds use non-blocking (<=) only.
  always_comb begin
    logic load;
    load     = 1'b0;
    pop      = 1'b0;
    state_d  = state_q;
    timer_d  = timer_q;
    period_d = period_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
`ifdef IO_UART_TX_PARITY_EN
    par_d    = par_q;
`endif
    if (busy && !bit_done) timer_d = timer_q - 1'b1;

    case (state_q)
      ST_IDLE: load = start_cond;
      ST_START: if (bit_done) begin
        state_d = ST_DATA;
        tx_d    = shift_q[0];
        idx_d   = '0;
        timer_d = period_q - 1'b1;
      end
      ST_DATA: if (bit_done) begin
        timer_d = period_q - 1'b1;
        if (idx_q == 3'd7) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
`ifdef IO_UART_TX_PARITY_EN
          if (par_en_q) begin
            state_d = ST_PARITY;
            tx_d    = par_q;
          end
`endif
        end else begin
          idx_d   = idx_q + 1'b1;
          shift_d = shift_q >> 1;
          tx_d    = shift_q[1];
        end
      end
`ifdef IO_UART_TX_PARITY_EN
      ST_PARITY: if (bit_done) begin
        state_d = ST_STOP;
        tx_d    = 1'b1;
        timer_d = period_q - 1'b1;
      end
`endif
      ST_STOP: if (bit_done) begin
        state_d = ST_IDLE;
        load    = start_cond;
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Frame start: pop the head byte and latch the divisor for the whole frame.
    if (load) begin
      pop      = 1'b1;
      state_d  = ST_START;
      tx_d     = 1'b0;
      period_d = div_eff;
      timer_d  = div_eff - 1'b1;
      shift_d  = fifo_rdata;
`ifdef IO_UART_TX_PARITY_EN
      par_d    = ^fifo_rdata;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      period_q <= DIV_W'(1);
      idx_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      period_q <= period_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      irq_q    <= irq_en_q && fifo_empty && !busy;
    end
  end

  always_comb begin
    csr_word                  = '0;
    csr_word[CSR_EN]          = en_q;
    csr_word[CSR_IRQ_EN]      = irq_en_q;
    csr_word[CSR_PAR_EN]      = par_en_q;
    csr_word[CSR_OVF]         = ovf_q;
    csr_word[CSR_FULL]        = fifo_full;
    csr_word[CSR_EMPTY]       = fifo_empty;
    csr_word[CSR_BUSY]        = busy;
    csr_word[CSR_COUNT_LSB+:8] = 8'(fifo_count);
  end

  always_comb begin
    rdata_d = '0;
    if (io_addr == A_CSR)      rdata_d = DATA_W'(csr_word);
    else if (io_addr == A_DIV) rdata_d = DATA_W'(div_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rdata_q <= '0;
    else      rdata_q <= rdata_d;
  end

  assign io_rdata = rdata_q;
  assign uart_tx  = tx_q;
  assign irq      = irq_q;

endmodule
